operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 157 +++++++++++++++
 tb/tb_operand_fetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch / write-back sequencer around an external ALU.
// An 8x8 register file feeds the ALU through a four-phase IDLE/FETCH/EXEC/WB cycle.
module operand_fetch #(
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  a1,
    output logic [7:0]  a2,
    output logic [4:0]  control,
    output logic        enable,
    input  logic [7:0]  alu_o,
    input  logic [2:0]  alu_status,
    output logic [2:0]  flags,
    output logic        done,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);

    localparam logic [4:0] OP_NOP = 5'b11111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t      state_r;
    logic [4:0]  op_r;
    logic [2:0]  rd_r;
    logic [2:0]  rs1_r;
    logic [2:0]  rs2_r;
    logic        imm_sel_r;
    logic [7:0]  imm_r;
    logic [7:0]  rf_r [8];
    logic [7:0]  a1_r;
    logic [7:0]  a2_r;
    logic [4:0]  control_r;
    logic        enable_r;
    logic        done_r;
    logic [2:0]  flags_r;
    logic        ready_r;
    logic        rf_we_s;
    logic        unused_reserved_s;

    // Register 0 reads as zero when it is hard-wired.
    function automatic logic [7:0] r0_mask(input logic [2:0] addr, input logic [7:0] val);
        if (ZERO_R0 && (addr == 3'd0)) begin
            return 8'h00;
        end else begin
            return val;
        end
    endfunction

    assign unused_reserved_s = instr[8];

    // Write-back enable: real ops only, and never into a hard-wired register 0.
    always_comb begin
        rf_we_s = 1'b0;
        if ((state_r == WB) && (op_r != OP_NOP) && !(ZERO_R0 && (rd_r == 3'd0))) begin
            rf_we_s = 1'b1;
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // Register file storage; cleared by reset, written only at the end of WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                rf_r[i] <= 8'h00;
            end
        end else if (rf_we_s) begin
            rf_r[rd_r] <= alu_o;
        end
    end

    // Sequencer and all registered outputs; enable and done are set on entry to their phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            op_r      <= 5'd0;
            rd_r      <= 3'd0;
            rs1_r     <= 3'd0;
            rs2_r     <= 3'd0;
            imm_sel_r <= 1'b0;
            imm_r     <= 8'h00;
            a1_r      <= 8'h00;
            a2_r      <= 8'h00;
            control_r <= 5'd0;
            enable_r  <= 1'b0;
            done_r    <= 1'b0;
            flags_r   <= 3'b000;
            ready_r   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (instr_valid) begin
                        op_r      <= instr[23:19];
                        rd_r      <= instr[18:16];
                        rs1_r     <= instr[15:13];
                        rs2_r     <= instr[12:10];
                        imm_sel_r <= instr[9];
                        imm_r     <= instr[7:0];
                        ready_r   <= 1'b0;
                        state_r   <= FETCH;
                    end else begin
                        ready_r   <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                FETCH: begin
                    a1_r      <= r0_mask(rs1_r, rf_r[rs1_r]);
                    a2_r      <= imm_sel_r ? imm_r : r0_mask(rs2_r, rf_r[rs2_r]);
                    control_r <= op_r;
                    enable_r  <= (op_r != OP_NOP);
                    state_r   <= EXEC;
                end
                EXEC: begin
                    enable_r <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= WB;
                end
                WB: begin
                    if (op_r != OP_NOP) begin
                        flags_r <= alu_status;
                    end else begin
                        flags_r <= flags_r;
                    end
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    enable_r <= 1'b0;
                    done_r   <= 1'b0;
                    ready_r  <= 1'b1;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign instr_ready = ready_r;
    assign a1          = a1_r;
    assign a2          = a2_r;
    assign control     = control_r;
    assign enable      = enable_r;
    assign done        = done_r;
    assign flags       = flags_r;
    assign dbg_data    = r0_mask(dbg_addr, rf_r[dbg_addr]);

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: two instances (ZERO_R0 = 0 and 1) checked every cycle
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] instr = 24'h0;
    logic        instr_valid = 1'b0;
    logic [2:0]  dbg_addr = 3'd0;

    logic        ready_0, ready_1, enable_0, enable_1, done_0, done_1;
    logic [7:0]  a1_0, a1_1, a2_0, a2_1, dbg_0, dbg_1;
    logic [4:0]  control_0, control_1;
    logic [2:0]  flags_0, flags_1;
    logic [7:0]  alu_o_0 = 8'h00, alu_o_1 = 8'h00;
    logic [2:0]  status_0 = 3'b000, status_1 = 3'b000;

    int n_checks = 0;
    int n_fail = 0;

    operand_fetch #(.ZERO_R0(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(ready_0), .a1(a1_0), .a2(a2_0), .control(control_0),
        .enable(enable_0), .alu_o(alu_o_0), .alu_status(status_0), .flags(flags_0),
        .done(done_0), .dbg_addr(dbg_addr), .dbg_data(dbg_0)
    );

    operand_fetch #(.ZERO_R0(1'b1)) u1 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(ready_1), .a1(a1_1), .a2(a2_1), .control(control_1),
        .enable(enable_1), .alu_o(alu_o_1), .alu_status(status_1), .flags(flags_1),
        .done(done_1), .dbg_addr(dbg_addr), .dbg_data(dbg_1)
    );

    always #5 clk = ~clk;

    // ALU behaviour: {status, result}; status = {zero, sign, parity}.
    function automatic logic [10:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd11:   r = b;
            default: r = a ^ b ^ {3'b000, op};
        endcase
        return {(r == 8'h00), r[7], ^r, r};
    endfunction

    // ALUs act on the rising edge of their strobe.
    always @(posedge enable_0) begin
        #1;
        {status_0, alu_o_0} = alu_f(control_0, a1_0, a2_0);
    end
    always @(posedge enable_1) begin
        #1;
        {status_1, alu_o_1} = alu_f(control_1, a1_1, a2_1);
    end

    // Reference model: age = cycles since the accepting edge (0 = idle).
    int         age_m = 0;
    logic [4:0] m_op;
    logic [2:0] m_rd, m_rs1, m_rs2;
    logic       m_isel;
    logic [7:0] m_imm;
    logic [7:0] rf_m [2][8];
    logic [7:0] ea1 [2];
    logic [7:0] ea2 [2];
    logic [4:0] ectl;
    logic [2:0] eflags [2];

    function automatic logic [7:0] rd_m(input int k, input logic [2:0] a);
        return (k == 1 && a == 3'd0) ? 8'h00 : rf_m[k][a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_m = 0;
            ectl = 5'd0;
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 8; i++) rf_m[k][i] = 8'h00;
                ea1[k] = 8'h00;
                ea2[k] = 8'h00;
                eflags[k] = 3'b000;
            end
        end else if (age_m == 0) begin
            if (instr_valid) begin
                {m_op, m_rd, m_rs1, m_rs2, m_isel} = instr[23:9];
                m_imm = instr[7:0];
                age_m = 1;
            end
        end else if (age_m == 1) begin
            for (int k = 0; k < 2; k++) begin
                ea1[k] = rd_m(k, m_rs1);
                ea2[k] = m_isel ? m_imm : rd_m(k, m_rs2);
            end
            ectl = m_op;
            age_m = 2;
        end else if (age_m == 2) begin
            age_m = 3;
        end else begin
            if (m_op != 5'b11111) begin
                for (int k = 0; k < 2; k++) begin
                    logic [10:0] r;
                    r = alu_f(ectl, ea1[k], ea2[k]);
                    if (!(k == 1 && m_rd == 3'd0)) rf_m[k][m_rd] = r[7:0];
                    eflags[k] = r[10:8];
                end
            end
            age_m = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.instr_ready", k), (k == 0) ? ready_0 : ready_1, age_m == 0);
            check($sformatf("u%0d.enable", k), (k == 0) ? enable_0 : enable_1,
                  (age_m == 2) && (ectl != 5'b11111));
            check($sformatf("u%0d.done", k), (k == 0) ? done_0 : done_1, age_m == 3);
            check($sformatf("u%0d.a1", k), (k == 0) ? a1_0 : a1_1, ea1[k]);
            check($sformatf("u%0d.a2", k), (k == 0) ? a2_0 : a2_1, ea2[k]);
            check($sformatf("u%0d.control", k), (k == 0) ? control_0 : control_1, ectl);
            check($sformatf("u%0d.flags", k), (k == 0) ? flags_0 : flags_1, eflags[k]);
            check($sformatf("u%0d.dbg_data", k), (k == 0) ? dbg_0 : dbg_1, rd_m(k, dbg_addr));
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (age_m != 0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("idle_timeout", age_m == 0, 1'b1);
    endtask

    // Issue one instruction (called at posedge+2 while idle); returns at posedge+2 after done.
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic isel, input logic [7:0] imm, input bit pin);
        int n = 0;
        instr = {op, rd, rs1, rs2, isel, 1'b0, imm};
        instr_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (age_m != 1 && n < 20);
        instr_valid = 1'b0;
        check("accept_timeout", age_m == 1, 1'b1);
        @(negedge clk);
        if (pin) check("pin_ready_fetch", ready_0, 1'b0);
        @(negedge clk);
        if (pin) check("pin_enable_exec", enable_0, op != 5'b11111);
        @(negedge clk);
        if (pin) check("pin_done_wb", done_0, 1'b1);
        if (pin) check("pin_enable_wb", enable_0, 1'b0);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int hs, nd, first_d, last_d, n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_ready", ready_0, 1'b1);
        check("reset_a1", a1_0, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Load operands through the pass-through op, then add.
        issue(5'b01011, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 1'b0);
        issue(5'b01011, 3'd2, 3'd0, 3'd0, 1'b1, 8'h03, 1'b0);
        issue(5'b00000, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 1'b1);
        check("pin_add_a1", a1_0, 8'h05);
        check("pin_add_a2", a2_0, 8'h03);
        dbg_addr = 3'd3;
        @(negedge clk);
        check("pin_rf3", dbg_0, 8'h08);
        check("pin_model_rf3", rf_m[0][3], 8'h08);
        @(posedge clk);
        #2;

        issue(5'b01011, 3'd4, 3'd1, 3'd2, 1'b1, 8'hA5, 1'b1);
        dbg_addr = 3'd4;
        check("pin_imm_a2", a2_0, 8'hA5);
        @(negedge clk);
        check("pin_rf4", dbg_0, 8'hA5);
        @(posedge clk);
        #2;

        // ZERO_R0 behaviour: 0F & 07 = 07, status 3'b001.
        issue(5'b01011, 3'd1, 3'd0, 3'd0, 1'b1, 8'h0F, 1'b0);
        issue(5'b00010, 3'd0, 3'd1, 3'd0, 1'b1, 8'h07, 1'b1);
        dbg_addr = 3'd0;
        @(negedge clk);
        check("pin_r0_zero", dbg_1, 8'h00);
        check("pin_r0_plain", dbg_0, 8'h07);
        check("pin_r0_flags", flags_1, 3'b001);
        @(posedge clk);
        #2;

        // NOP: no strobe, no write, flags held.
        issue(5'b11111, 3'd1, 3'd1, 3'd2, 1'b0, 8'h00, 1'b1);
        dbg_addr = 3'd1;
        @(negedge clk);
        check("pin_nop_rf1", dbg_0, 8'h0F);
        check("pin_nop_flags", flags_0, 3'b001);
        @(posedge clk);
        #2;

        // instr_valid held for 10 edges.
        instr = {5'd1, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0, 8'h00};
        instr_valid = 1'b1;
        hs = 0; nd = 0; first_d = -1; last_d = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (ready_0 && instr_valid) hs++;
            if (done_0) begin
                nd++;
                if (first_d < 0) first_d = i;
                last_d = i;
            end
            if (i == 9) begin
                @(posedge clk);
                #1 instr_valid = 1'b0;
            end
        end
        check("hold_handshakes", hs, 3);
        check("hold_dones", nd, 3);
        check("hold_done_span", last_d - first_d, 8);
        @(posedge clk);
        #2;
        wait_idle();

        // Random traffic, including instruction changes outside IDLE.
        for (int c = 0; c < 400; c++) begin
            logic [4:0] op;
            op = ($urandom_range(0, 7) == 0) ? 5'b11111 : 5'($urandom_range(0, 30));
            instr = {op, 19'($urandom())};
            instr_valid = 1'($urandom_range(0, 1));
            dbg_addr = 3'($urandom_range(0, 7));
            @(posedge clk);
            #2;
        end
        instr_valid = 1'b0;
        wait_idle();

        // Reset during EXEC aborts the instruction.
        instr = {5'd0, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0, 8'h00};
        instr_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (age_m != 2 && n < 20);
        instr_valid = 1'b0;
        check("exec_timeout", age_m == 2, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_enable0", enable_0, 1'b0);
        check("abort_enable1", enable_1, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        dbg_addr = 3'd5;
        @(negedge clk);
        check("abort_ready", ready_0, 1'b1);
        check("abort_rf5", dbg_0, 8'h00);
        check("abort_flags", flags_0, 3'b000);
        @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
